// File: rtl/ay38500_pkg.sv
// Shared definitions for the AY-3-8500 front-end emulation blocks.
// Paddle input modes and default digital move steps.
package ay38500_pkg;

    typedef enum logic [1:0] {
        PAD_DIGITAL = 2'd0,
        PAD_Y       = 2'd1,
        PAD_X       = 2'd2,
        PAD_XINV    = 2'd3
    } pad_mode_e;

    localparam int unsigned STEP_SLOW_DEF = 5;
    localparam int unsigned STEP_FAST_DEF = 8;

endpackage

// File: rtl/sync_edge_det.sv
// One-cycle rising-edge pulse from a clk_sys-synchronous level.
// The pulse is combinational from the level and its delayed copy.
module sync_edge_det (
    input  logic clk_sys,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_d;

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/paddle_charge_emu.sv
// Paddle potentiometer/capacitor emulation: loads a charge count each frame
// and discharges it per scanline; pin_out fires when the count reaches zero.
module paddle_charge_emu
    import ay38500_pkg::*;
#(
    parameter int unsigned POS_INIT  = 128,
    parameter int unsigned POS_MAX   = 255,
    parameter int unsigned STEP_SLOW = STEP_SLOW_DEF,
    parameter int unsigned STEP_FAST = STEP_FAST_DEF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic [1:0]  mode,
    input  logic        speed,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [15:0] analog,
    output logic        pin_out,
    output logic [7:0]  charge,
    output logic [7:0]  pos
);

    logic      hs_rise;
    logic      vs_rise;
    pad_mode_e mode_e;
    logic [8:0] step9;
    logic [8:0] pos_add9;
    logic [8:0] pos_sub9;
    logic [7:0] pos_next;
    logic [7:0] analog_charge;

    sync_edge_det u_hs_edge (
        .clk_sys (clk_sys),
        .reset   (reset),
        .level   (hs),
        .rise    (hs_rise)
    );

    sync_edge_det u_vs_edge (
        .clk_sys (clk_sys),
        .reset   (reset),
        .level   (vs),
        .rise    (vs_rise)
    );

    assign mode_e = pad_mode_e'(mode);

    // Position arithmetic at 9 bits so both saturation checks see the carry/borrow.
    always_comb begin
        step9    = speed ? 9'(STEP_FAST) : 9'(STEP_SLOW);
        pos_add9 = {1'b0, pos} + step9;
        pos_sub9 = {1'b0, pos} - step9;
        pos_next = pos;
        if (btn_down) begin
            pos_next = (pos_add9 > 9'(POS_MAX)) ? 8'(POS_MAX) : pos_add9[7:0];
        end else if (btn_up) begin
            pos_next = ({1'b0, pos} < step9) ? '0 : pos_sub9[7:0];
        end
    end

    always_comb begin
        analog_charge = pos;
        case (mode_e)
            PAD_Y:    analog_charge = {~analog[15], analog[14:8]};
            PAD_X:    analog_charge = {~analog[7], analog[6:0]};
            PAD_XINV: analog_charge = {analog[7], ~analog[6:0]};
            default:  analog_charge = pos;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            pos    <= 8'(POS_INIT);
            charge <= '0;
        end else if (vs_rise) begin
            if (mode_e == PAD_DIGITAL) begin
                charge <= pos;
                pos    <= pos_next;
            end else begin
                charge <= analog_charge;
            end
        end else if (hs_rise && (charge != '0)) begin
            charge <= charge - 8'd1;
        end
    end

    assign pin_out = (charge == '0);

endmodule

// File: tb/tb_paddle_charge_emu.sv
// Directed bench for paddle_charge_emu: digital stepping, analog mappings,
// discharge timing, load priority and asynchronous reset.
module tb_paddle_charge_emu;

    logic        clk_sys;
    logic        reset;
    logic        hs;
    logic        vs;
    logic [1:0]  mode;
    logic        speed;
    logic        btn_up;
    logic        btn_down;
    logic [15:0] analog;
    logic        pin_out;
    logic [7:0]  charge;
    logic [7:0]  pos;

    int unsigned checks;
    int unsigned errors;

    paddle_charge_emu #(
        .POS_INIT  (128),
        .POS_MAX   (255),
        .STEP_SLOW (5),
        .STEP_FAST (8)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .hs       (hs),
        .vs       (vs),
        .mode     (mode),
        .speed    (speed),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .analog   (analog),
        .pin_out  (pin_out),
        .charge   (charge),
        .pos      (pos)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // vs high for one cycle, then idle cycle; charge/pos settle before return
    task automatic frame();
        @(negedge clk_sys) vs = 1'b1;
        @(negedge clk_sys) vs = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic line();
        @(negedge clk_sys) hs = 1'b1;
        @(negedge clk_sys) hs = 1'b0;
    endtask

    initial begin
        int unsigned exp_pos;
        int unsigned old_pos;
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        hs       = 1'b0;
        vs       = 1'b0;
        mode     = 2'd0;
        speed    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        analog   = 16'h0000;

        repeat (3) @(negedge clk_sys);
        check("reset_pos", 16'(pos), 16'd128);
        check("reset_charge", 16'(charge), 16'd0);
        check("reset_pin", 16'(pin_out), 16'd1);
        reset = 1'b1;
        @(negedge clk_sys);

        // Mode 0 idle frame then discharge: pin fires on the 128th line
        frame();
        check("load_charge", 16'(charge), 16'd128);
        check("load_pin", 16'(pin_out), 16'd0);
        check("idle_pos", 16'(pos), 16'd128);
        for (int i = 1; i <= 130; i++) begin
            line();
            @(negedge clk_sys);
            check($sformatf("dis_pin_%0d", i), 16'(pin_out), (i >= 128) ? 16'd1 : 16'd0);
            check($sformatf("dis_chg_%0d", i), 16'(charge), (i >= 128) ? 16'd0 : 16'(128 - i));
        end

        // btn_up slow: 123,118,...,3,0 then held at 0
        btn_up  = 1'b1;
        exp_pos = 128;
        for (int f = 1; f <= 30; f++) begin
            old_pos = exp_pos;
            exp_pos = (exp_pos < 5) ? 0 : exp_pos - 5;
            frame();
            check($sformatf("up_pos_%0d", f), 16'(pos), 16'(exp_pos));
            check($sformatf("up_chg_%0d", f), 16'(charge), 16'(old_pos));
        end
        check("up_floor", 16'(pos), 16'd0);
        btn_up = 1'b0;

        // btn_down slow from 0 to 250 (50 frames)
        btn_down = 1'b1;
        repeat (50) frame();
        check("down_250", 16'(pos), 16'd250);
        speed = 1'b1;
        frame();
        check("down_sat", 16'(pos), 16'd255);
        check("down_sat_chg", 16'(charge), 16'd250);
        frame();
        check("down_hold", 16'(pos), 16'd255);
        btn_down = 1'b0;

        // up slow 31 frames from 255 -> 100, then both buttons fast -> 108
        speed  = 1'b0;
        btn_up = 1'b1;
        repeat (31) frame();
        check("up_100", 16'(pos), 16'd100);
        speed    = 1'b1;
        btn_down = 1'b1;
        frame();
        check("both_down_wins", 16'(pos), 16'd108);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        speed    = 1'b0;

        // Analog mappings
        mode   = 2'd1;
        analog = 16'h8000;
        frame();
        check("y80_chg", 16'(charge), 16'd0);
        check("y80_pin", 16'(pin_out), 16'd1);
        repeat (5) line();
        @(negedge clk_sys);
        check("y80_pin_lines", 16'(pin_out), 16'd1);
        check("y80_chg_lines", 16'(charge), 16'd0);
        analog = 16'h7F00;
        frame();
        check("y7f_chg", 16'(charge), 16'd255);
        mode   = 2'd2;
        analog = 16'h0000;
        frame();
        check("x00_chg", 16'(charge), 16'd128);
        mode = 2'd3;
        frame();
        check("xinv00_chg", 16'(charge), 16'd127);
        check("analog_pos_kept", 16'(pos), 16'd108);

        // Reach pos=40: one fast up (100), then 12 slow up (40); last load gives charge 45
        mode   = 2'd0;
        btn_up = 1'b1;
        speed  = 1'b1;
        frame();
        check("fast_up_100", 16'(pos), 16'd100);
        speed = 1'b0;
        repeat (12) frame();
        check("pos_40", 16'(pos), 16'd40);
        check("chg_45", 16'(charge), 16'd45);
        btn_up = 1'b0;

        // Mid-frame mode change does not disturb the running count
        mode = 2'd1;
        analog = 16'h7F00;
        repeat (35) line();
        @(negedge clk_sys);
        check("midframe_chg", 16'(charge), 16'd10);
        mode = 2'd0;

        // vs and hs rise together: load wins, no decrement
        @(negedge clk_sys) begin
            vs = 1'b1;
            hs = 1'b1;
        end
        @(negedge clk_sys) begin
            vs = 1'b0;
            hs = 1'b0;
        end
        @(negedge clk_sys);
        check("simul_chg", 16'(charge), 16'd40);
        check("simul_pos", 16'(pos), 16'd40);

        // Load 60 via mode 2 (X = -68), then async reset mid-cycle
        mode   = 2'd2;
        analog = 16'h00BC;
        frame();
        check("x_chg_60", 16'(charge), 16'd60);
        #2 reset = 1'b0;
        #1;
        check("async_rst_chg", 16'(charge), 16'd0);
        check("async_rst_pin", 16'(pin_out), 16'd1);
        @(negedge clk_sys) reset = 1'b1;
        mode = 2'd0;
        @(negedge clk_sys);
        check("post_rst_pos", 16'(pos), 16'd128);
        check("post_rst_chg", 16'(charge), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
